iomem_timer: RTL and testbench

IOMEM_TIMER -- requirements
Module: iomem_timer

---
 rtl/iomem_if.sv | 28 ++
 rtl/iomem_timer.sv | 145 ++++++++++++++
 tb/tb_iomem_timer.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/iomem_if.sv
// iomem_if: PicoSoC-style iomem bus between an initiator and a responder.
// The master drives the request fields and the slave returns ready and read data.
interface iomem_if;
   logic        iomem_valid;
   logic        iomem_ready;
   logic [3:0]  iomem_wstrb;
   logic [31:0] iomem_addr;
   logic [31:0] iomem_wdata;
   logic [31:0] iomem_rdata;

   modport slave (
      input  iomem_valid,
      input  iomem_wstrb,
      input  iomem_addr,
      input  iomem_wdata,
      output iomem_ready,
      output iomem_rdata
   );

   modport master (
      output iomem_valid,
      output iomem_wstrb,
      output iomem_addr,
      output iomem_wdata,
      input  iomem_ready,
      input  iomem_rdata
   );
endinterface

// File: rtl/iomem_timer.sv
// iomem_timer: memory-mapped down-counting timer with a prescaler, optional auto
// reload and a level interrupt. Every access takes one wait state, and outputs
// stay at zero when the block is not addressed, so several responders can be OR-ed.
module iomem_timer #(
   parameter logic [31:0] BASE_ADDR = 32'h0300_0000
) (
   input  logic   clk,
   input  logic   reset,
   iomem_if.slave bus,
   output logic   irq
);

   logic        sel;
   logic        ack;
   logic        wr;
   logic [2:0]  offset;
   logic        readyQ, readyD;
   logic [2:0]  ctrlQ, ctrlD;
   logic [15:0] prescQ, prescD;
   logic [31:0] prescMerged;
   logic [31:0] loadQ, loadD;
   logic [31:0] countQ, countD, countTick;
   logic        expiredQ, expiredD;
   logic [15:0] pcntQ, pcntD;
   logic        tick;
   logic [31:0] readMux;
   logic        unusedAddrBits;

   // Byte-lane merge: lanes with a strobe take the new byte, the rest keep the old one.
   function automatic logic [31:0] mergeLanes(input logic [31:0] oldVal,
                                              input logic [31:0] newVal,
                                              input logic [3:0]  strb);
      logic [31:0] r;
      r = oldVal;
      for (int i = 0; i < 4; i++) begin
         if (strb[i]) begin
            r[8*i +: 8] = newVal[8*i +: 8];
         end
      end
      return r;
   endfunction

   // The low address bits only select bytes inside a word and are not decoded.
   assign unusedAddrBits = &{1'b0, bus.iomem_addr[1:0]};

   // Address decode and acknowledge; ack is gated by sel so a dropped request
   // never sees ready or commits a write.
   always_comb begin
      sel    = bus.iomem_valid && (bus.iomem_addr[31:5] == BASE_ADDR[31:5]);
      offset = bus.iomem_addr[4:2];
      readyD = sel && !readyQ;
      ack    = readyQ && sel;
      wr     = ack && (bus.iomem_wstrb != 4'b0000);
   end

   // Prescaler: a tick fires when the count matches PRESC; the count is held at
   // zero while disabled and restarts on any CTRL or PRESC write.
   always_comb begin
      tick  = ctrlQ[0] && (pcntQ == prescQ);
      pcntD = pcntQ + 16'd1;
      if (wr && (offset == 3'd0 || offset == 3'd1)) begin
         pcntD = 16'd0;
      end else if (!ctrlQ[0] || tick) begin
         pcntD = 16'd0;
      end
   end

   // Register next state; bus writes to COUNT override the tick result lane by
   // lane, and an expiry wins over a same-cycle write-1-to-clear of EXPIRED.
   always_comb begin
      ctrlD       = ctrlQ;
      prescMerged = mergeLanes({16'h0000, prescQ}, bus.iomem_wdata, bus.iomem_wstrb);
      prescD      = prescQ;
      loadD       = loadQ;
      expiredD    = expiredQ;
      countTick   = countQ;
      if (tick) begin
         if (countQ > 32'd1) begin
            countTick = countQ - 32'd1;
         end else if (countQ == 32'd1) begin
            countTick = ctrlQ[1] ? loadQ : 32'd0;
         end
      end
      countD = countTick;
      if (wr) begin
         case (offset)
            3'd0: begin
               if (bus.iomem_wstrb[0]) begin
                  ctrlD = bus.iomem_wdata[2:0];
               end
            end
            3'd1: prescD = prescMerged[15:0];
            3'd2: loadD  = mergeLanes(loadQ, bus.iomem_wdata, bus.iomem_wstrb);
            3'd3: countD = mergeLanes(countTick, bus.iomem_wdata, bus.iomem_wstrb);
            3'd4: begin
               if (bus.iomem_wstrb[0] && bus.iomem_wdata[0]) begin
                  expiredD = 1'b0;
               end
            end
            default: ;
         endcase
      end
      if (tick && countQ == 32'd1) begin
         expiredD = 1'b1;
      end
   end

   // Read data mux, forced to zero outside the acknowledge cycle.
   always_comb begin
      readMux = 32'd0;
      case (offset)
         3'd0:    readMux = {29'd0, ctrlQ};
         3'd1:    readMux = {16'd0, prescQ};
         3'd2:    readMux = loadQ;
         3'd3:    readMux = countQ;
         3'd4:    readMux = {31'd0, expiredQ};
         default: readMux = 32'd0;
      endcase
      bus.iomem_ready = ack;
      bus.iomem_rdata = ack ? readMux : 32'd0;
      irq             = expiredQ && ctrlQ[2];
   end

   // All state registers, cleared asynchronously so an in-flight write is dropped.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         readyQ   <= 1'b0;
         ctrlQ    <= 3'd0;
         prescQ   <= 16'd0;
         loadQ    <= 32'd0;
         countQ   <= 32'd0;
         expiredQ <= 1'b0;
         pcntQ    <= 16'd0;
      end else begin
         readyQ   <= readyD;
         ctrlQ    <= ctrlD;
         prescQ   <= prescD;
         loadQ    <= loadD;
         countQ   <= countD;
         expiredQ <= expiredD;
         pcntQ    <= pcntD;
      end
   end

endmodule

// File: tb/tb_iomem_timer.sv
// tb_iomem_timer: table-driven register checks plus hand-written timing sequences.
// Expected read data is queued when a read is issued and compared when ready appears.
module tb_iomem_timer;

   localparam logic [31:0] BASE = 32'h0300_0000;

   logic clk;
   logic reset;
   logic irq;
   int   assertCount;
   int   failCount;

   logic [31:0] expQueue[$];

   typedef struct {
      logic        isWrite;
      logic [31:0] addr;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
      logic [31:0] expRdata;
   } vec_t;

   vec_t vecs[21];

   iomem_if bus ();

   iomem_timer #(.BASE_ADDR(BASE)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave),
      .irq   (irq)
   );

   // Free-running clock, 10 time units per cycle.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog so the run always ends on its own.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   // One bus transfer: ready must rise after exactly one edge, last one cycle,
   // and read results are compared by the monitor from the queue.
   task automatic applyStimulus(input logic isWrite, input logic [31:0] addr,
                                input logic [3:0] wstrb, input logic [31:0] wdata,
                                input logic [31:0] expRdata);
      @(negedge clk);
      bus.iomem_valid = 1'b1;
      bus.iomem_addr  = addr;
      bus.iomem_wstrb = isWrite ? wstrb : 4'b0000;
      bus.iomem_wdata = wdata;
      if (!isWrite) expQueue.push_back(expRdata);
      @(posedge clk);
      #1;
      checkOutput("ready latency", {31'd0, bus.iomem_ready}, 32'd1);
      @(posedge clk);
      #1;
      checkOutput("ready pulse width", {31'd0, bus.iomem_ready}, 32'd0);
      bus.iomem_valid = 1'b0;
      bus.iomem_wstrb = 4'b0000;
   endtask

   // Scoreboard monitor: every read acknowledge pops one expected value.
   always @(negedge clk) begin
      if (bus.iomem_ready && bus.iomem_wstrb == 4'b0000) begin
         if (expQueue.size() == 0) begin
            checkOutput("unexpected read ack", 32'd1, 32'd0);
         end else begin
            checkOutput("read data", bus.iomem_rdata, expQueue.pop_front());
         end
      end
   end

   initial begin
      logic [31:0] expCount;
      assertCount      = 0;
      failCount        = 0;
      bus.iomem_valid  = 1'b0;
      bus.iomem_addr   = 32'd0;
      bus.iomem_wstrb  = 4'b0000;
      bus.iomem_wdata  = 32'd0;

      vecs[0]  = '{1'b0, BASE + 32'h08, 4'h0, 32'h0,         32'h0};
      vecs[1]  = '{1'b0, BASE + 32'h00, 4'h0, 32'h0,         32'h0};
      vecs[2]  = '{1'b0, BASE + 32'h04, 4'h0, 32'h0,         32'h0};
      vecs[3]  = '{1'b0, BASE + 32'h0C, 4'h0, 32'h0,         32'h0};
      vecs[4]  = '{1'b0, BASE + 32'h10, 4'h0, 32'h0,         32'h0};
      vecs[5]  = '{1'b1, BASE + 32'h04, 4'hF, 32'hABCD_1234, 32'h0};
      vecs[6]  = '{1'b0, BASE + 32'h04, 4'h0, 32'h0,         32'h0000_1234};
      vecs[7]  = '{1'b1, BASE + 32'h08, 4'hF, 32'h1234_5678, 32'h0};
      vecs[8]  = '{1'b1, BASE + 32'h08, 4'h1, 32'h0000_00AA, 32'h0};
      vecs[9]  = '{1'b0, BASE + 32'h08, 4'h0, 32'h0,         32'h1234_56AA};
      vecs[10] = '{1'b1, BASE + 32'h00, 4'h1, 32'hFFFF_FFFE, 32'h0};
      vecs[11] = '{1'b0, BASE + 32'h00, 4'h0, 32'h0,         32'h0000_0006};
      vecs[12] = '{1'b1, BASE + 32'h14, 4'hF, 32'hFFFF_FFFF, 32'h0};
      vecs[13] = '{1'b0, BASE + 32'h14, 4'h0, 32'h0,         32'h0};
      vecs[14] = '{1'b0, BASE + 32'h1C, 4'h0, 32'h0,         32'h0};
      vecs[15] = '{1'b1, BASE + 32'h0C, 4'hC, 32'hDEAD_BEEF, 32'h0};
      vecs[16] = '{1'b0, BASE + 32'h0C, 4'h0, 32'h0,         32'hDEAD_0000};
      vecs[17] = '{1'b1, BASE + 32'h10, 4'hF, 32'h0000_0001, 32'h0};
      vecs[18] = '{1'b0, BASE + 32'h10, 4'h0, 32'h0,         32'h0};
      vecs[19] = '{1'b1, BASE + 32'h04, 4'h2, 32'h0000_FF00, 32'h0};
      vecs[20] = '{1'b0, BASE + 32'h04, 4'h0, 32'h0,         32'h0000_FF34};

      // Reset state
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset ready", {31'd0, bus.iomem_ready}, 32'd0);
      checkOutput("reset rdata", bus.iomem_rdata, 32'd0);
      checkOutput("reset irq", {31'd0, irq}, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // Register table
      for (int i = 0; i < 21; i++) begin
         applyStimulus(vecs[i].isWrite, vecs[i].addr, vecs[i].wstrb,
                       vecs[i].wdata, vecs[i].expRdata);
      end
      checkOutput("irq after table", {31'd0, irq}, 32'd0);

      // Auto-reload every cycle: 3,2,1 then reload to 3 with expiry
      applyStimulus(1'b1, BASE + 32'h08, 4'hF, 32'd3, 32'd0);
      applyStimulus(1'b1, BASE + 32'h0C, 4'hF, 32'd3, 32'd0);
      applyStimulus(1'b1, BASE + 32'h04, 4'hF, 32'd0, 32'd0);
      applyStimulus(1'b1, BASE + 32'h00, 4'hF, 32'd7, 32'd0);
      checkOutput("reload count0", dut.countQ, 32'd3);
      @(posedge clk); #1;
      checkOutput("reload count1", dut.countQ, 32'd2);
      @(posedge clk); #1;
      checkOutput("reload count2", dut.countQ, 32'd1);
      checkOutput("reload irq before", {31'd0, irq}, 32'd0);
      @(posedge clk); #1;
      checkOutput("reload count3", dut.countQ, 32'd3);
      checkOutput("reload irq", {31'd0, irq}, 32'd1);

      // Expiry collides with a write-1-to-clear of STATUS
      applyStimulus(1'b1, BASE + 32'h00, 4'hF, 32'd0, 32'd0);
      applyStimulus(1'b1, BASE + 32'h10, 4'hF, 32'd1, 32'd0);
      applyStimulus(1'b0, BASE + 32'h10, 4'h0, 32'd0, 32'd0);
      applyStimulus(1'b1, BASE + 32'h04, 4'hF, 32'd1, 32'd0);
      applyStimulus(1'b1, BASE + 32'h0C, 4'hF, 32'd1, 32'd0);
      applyStimulus(1'b1, BASE + 32'h00, 4'hF, 32'd5, 32'd0);
      applyStimulus(1'b1, BASE + 32'h10, 4'hF, 32'd1, 32'd0);
      checkOutput("collision irq", {31'd0, irq}, 32'd1);
      applyStimulus(1'b0, BASE + 32'h10, 4'h0, 32'd0, 32'd1);
      applyStimulus(1'b0, BASE + 32'h0C, 4'h0, 32'd0, 32'd0);
      applyStimulus(1'b1, BASE + 32'h10, 4'hF, 32'd1, 32'd0);
      applyStimulus(1'b0, BASE + 32'h10, 4'h0, 32'd0, 32'd0);
      checkOutput("cleared irq", {31'd0, irq}, 32'd0);

      // Prescaled countdown with IRQ_EN off
      applyStimulus(1'b1, BASE + 32'h00, 4'hF, 32'd0, 32'd0);
      applyStimulus(1'b1, BASE + 32'h04, 4'hF, 32'd4, 32'd0);
      applyStimulus(1'b1, BASE + 32'h0C, 4'hF, 32'd2, 32'd0);
      applyStimulus(1'b1, BASE + 32'h00, 4'hF, 32'd1, 32'd0);
      checkOutput("presc count start", dut.countQ, 32'd2);
      for (int k = 1; k <= 14; k++) begin
         @(posedge clk); #1;
         expCount = (k < 5) ? 32'd2 : ((k < 10) ? 32'd1 : 32'd0);
         checkOutput($sformatf("presc count k=%0d", k), dut.countQ, expCount);
         checkOutput($sformatf("presc irq k=%0d", k), {31'd0, irq}, 32'd0);
      end
      applyStimulus(1'b0, BASE + 32'h10, 4'h0, 32'd0, 32'd1);

      // Unmapped window: no ready, no data
      @(negedge clk);
      bus.iomem_valid = 1'b1;
      bus.iomem_addr  = 32'h0400_0000;
      bus.iomem_wstrb = 4'b0000;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checkOutput("unmapped ready", {31'd0, bus.iomem_ready}, 32'd0);
         checkOutput("unmapped rdata", bus.iomem_rdata, 32'd0);
      end
      bus.iomem_valid = 1'b0;

      // Reset in the middle of a LOAD write while counting
      applyStimulus(1'b1, BASE + 32'h0C, 4'hF, 32'd100, 32'd0);
      applyStimulus(1'b1, BASE + 32'h00, 4'hF, 32'd5, 32'd0);
      @(negedge clk);
      bus.iomem_valid = 1'b1;
      bus.iomem_addr  = BASE + 32'h08;
      bus.iomem_wstrb = 4'hF;
      bus.iomem_wdata = 32'h5555_5555;
      @(posedge clk); #1;
      checkOutput("mid-write ready", {31'd0, bus.iomem_ready}, 32'd1);
      reset = 1'b1;
      #1;
      checkOutput("reset ready async", {31'd0, bus.iomem_ready}, 32'd0);
      checkOutput("reset irq async", {31'd0, irq}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      bus.iomem_valid = 1'b0;
      bus.iomem_wstrb = 4'b0000;
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, BASE + 32'(4 * i), 4'h0, 32'd0, 32'd0);
      end
      checkOutput("post-reset irq", {31'd0, irq}, 32'd0);

      repeat (2) @(posedge clk);
      checkOutput("scoreboard drained", 32'(expQueue.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
